// File: rtl/branch_resolve_unit_pkg.sv
// Shared definitions for the branch resolve unit.
//  - funct3 encodings of the conditional branches
//  - FSM state enum (RUN / FLUSH / HALT)
//  - default reset PC
package branch_resolve_unit_pkg;

  localparam logic [2:0] F3_BEQ  = 3'b000;
  localparam logic [2:0] F3_BNE  = 3'b001;
  localparam logic [2:0] F3_BLT  = 3'b100;
  localparam logic [2:0] F3_BGE  = 3'b101;
  localparam logic [2:0] F3_BLTU = 3'b110;
  localparam logic [2:0] F3_BGEU = 3'b111;

  typedef enum logic [1:0] {
    RUN   = 2'd0,
    FLUSH = 2'd1,
    HALT  = 2'd2
  } state_e;

  localparam logic [63:0] RESET_PC_DEFAULT = 64'h0;

endpackage

// File: rtl/branch_resolve_unit_cond.sv
// branch_cond_decode: selects the ALU flag named by funct3.
//  funct3            in  branch condition code
//  equal..unsigned_* in  ALU comparison flags
//  cond              out condition true (0 for the reserved codes)
//  illegal           out funct3 is 010/011 (no such branch)
module branch_cond_decode
  import branch_resolve_unit_pkg::*;
(
  input  logic [2:0] funct3,
  input  logic       equal,
  input  logic       not_equal,
  input  logic       lesser_than,
  input  logic       greater_or_equal,
  input  logic       unsigned_lesser,
  input  logic       unsigned_greater_equal,
  output logic       cond,
  output logic       illegal
);

  always_comb begin
    cond    = 1'b0;
    illegal = 1'b0;
    case (funct3)
      F3_BEQ:  cond = equal;
      F3_BNE:  cond = not_equal;
      F3_BLT:  cond = lesser_than;
      F3_BGE:  cond = greater_or_equal;
      F3_BLTU: cond = unsigned_lesser;
      F3_BGEU: cond = unsigned_greater_equal;
      default: illegal = 1'b1;
    endcase
  end

endmodule

// File: rtl/branch_resolve_unit.sv
// branch_resolve_unit: resolves branches/jumps from the ALU flags, owns the
// fetch PC and squashes younger instructions for FLUSH_CYCLES after a redirect.
// Ports:
//  clk, reset (async, active high), stall
//  op_valid, is_branch, is_jal, is_jalr, funct3, op_pc, imm, rs1, six ALU flags
//  pc (registered fetch PC), link_addr (op_pc+4), taken (combinational)
//  flush, misaligned_exc, illegal_branch (registered)
//  branch_count, taken_count (saturating statistics)
module branch_resolve_unit
  import branch_resolve_unit_pkg::*;
#(
  parameter int              XLEN         = 64,
  parameter logic [XLEN-1:0] RESET_PC     = XLEN'(RESET_PC_DEFAULT),
  parameter int              FLUSH_CYCLES = 2,
  parameter int              CNT_W        = 32
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             stall,
  input  logic             op_valid,
  input  logic             is_branch,
  input  logic             is_jal,
  input  logic             is_jalr,
  input  logic [2:0]       funct3,
  input  logic [XLEN-1:0]  op_pc,
  input  logic [XLEN-1:0]  imm,
  input  logic [XLEN-1:0]  rs1,
  input  logic             equal,
  input  logic             not_equal,
  input  logic             lesser_than,
  input  logic             greater_or_equal,
  input  logic             unsigned_lesser,
  input  logic             unsigned_greater_equal,
  output logic [XLEN-1:0]  pc,
  output logic [XLEN-1:0]  link_addr,
  output logic             taken,
  output logic             flush,
  output logic             misaligned_exc,
  output logic             illegal_branch,
  output logic [CNT_W-1:0] branch_count,
  output logic [CNT_W-1:0] taken_count
);

  localparam logic [XLEN-1:0] PC_STEP  = XLEN'(4);
  localparam logic [2:0]      CNT_INIT = 3'(FLUSH_CYCLES - 1);
  localparam logic [CNT_W-1:0] CNT_MAX = '1;

  state_e          state;
  logic [2:0]      cnt;
  logic            cond, illegal;
  logic [XLEN-1:0] target;

  branch_cond_decode u_dec (
    .funct3                 (funct3),
    .equal                  (equal),
    .not_equal              (not_equal),
    .lesser_than            (lesser_than),
    .greater_or_equal       (greater_or_equal),
    .unsigned_lesser        (unsigned_lesser),
    .unsigned_greater_equal (unsigned_greater_equal),
    .cond                   (cond),
    .illegal                (illegal)
  );

  assign link_addr = op_pc + PC_STEP;
  // jalr clears bit 0 only; bit 1 survives and is caught as misaligned.
  assign target = is_jalr ? ((rs1 + imm) & ~XLEN'(1)) : (op_pc + imm);
  assign taken  = op_valid & (state == RUN) & (is_jal | is_jalr | (is_branch & cond));

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state          <= RUN;
      cnt            <= '0;
      pc             <= RESET_PC;
      flush          <= 1'b0;
      misaligned_exc <= 1'b0;
      illegal_branch <= 1'b0;
      branch_count   <= '0;
      taken_count    <= '0;
    end else begin
      // Pulses last exactly one cycle; stalled cycles never raise them.
      misaligned_exc <= 1'b0;
      illegal_branch <= 1'b0;
      case (state)
        RUN: if (!stall) begin
          if (taken && !target[1]) begin
            pc    <= target;
            flush <= 1'b1;
            cnt   <= CNT_INIT;
            state <= FLUSH;
          end else if (taken) begin
            misaligned_exc <= 1'b1;
            state          <= HALT;
          end else begin
            pc <= pc + PC_STEP;
          end
          if (op_valid && is_branch) begin
            illegal_branch <= illegal;
            if (branch_count != CNT_MAX) branch_count <= branch_count + 1'b1;
            if (cond && taken_count != CNT_MAX) taken_count <= taken_count + 1'b1;
          end
        end
        FLUSH: if (!stall) begin
          // Fetch keeps streaming from the new target while the squash runs.
          pc <= pc + PC_STEP;
          if (cnt == 3'd0) begin
            flush <= 1'b0;
            state <= RUN;
          end else begin
            cnt <= cnt - 3'd1;
          end
        end
        default: ;  // HALT: frozen until reset
      endcase
    end
  end

endmodule
